spi_reg_peripheral: RTL and testbench
=====================================

Name: spi_reg_peripheral

Overview:
- SPI target (mode 0) that receives 16-bit write frames from an off-chip controller.
- Maintains the five 8-bit control registers consumed by pwm_peripheral: output enables, PWM enables and duty cycle.
- Sits between the TinyTapeout ui_in pins (nCS, SCLK, COPI) and pwm_peripheral.
- All SPI inputs are asynchronous to clk and are synchronised internally.

Parameters:
SYNC_STAGES, 2, flip-flop stages per synchroniser on ncs/sclk/copi (minimum 2)
NUM_REGS, 5, number of valid register addresses (0..NUM_REGS-1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
ncs  input  1  SPI chip select, active low, async
sclk  input  1  SPI clock, async; sclk ≤ clk/8
copi  input  1  SPI data in, async
cipo  output  1  SPI data out; see Optional Feature
en_reg_out_7_0  output  8  reg 0x00
en_reg_out_15_8  output  8  reg 0x01
en_reg_pwm_7_0  output  8  reg 0x02
en_reg_pwm_15_8  output  8  reg 0x03
pwm_duty_cycle  output  8  reg 0x04
wr_strobe  output  1  one-cycle pulse when a register is written
wr_addr  output  7  address of the last accepted write

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All five registers, wr_strobe, wr_addr and cipo go to 0.
  - Synchronisers are set to idle values: ncs=1, sclk=0, copi=0. FSM goes to IDLE.
- Frame format, MSB first: bit15 R/W (1=write), bits14:8 address, bits7:0 data.
- Edge detection is done on the synchronised signals against a one-cycle-delayed copy.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on an ncs falling edge → SHIFT; clear shift register and bit counter.
  - SHIFT: on each sclk rising edge, shift in copi and increment the 5-bit counter, saturating at 17.
    - On an ncs rising edge → COMMIT.
    - sclk edges while ncs is high are ignored.
  - COMMIT, one cycle:
    - Write only if count==16, R/W==1 and addr<NUM_REGS.
    - On write: update the target register, set wr_addr, pulse wr_strobe this cycle.
    - Otherwise discard the frame with no register change and no strobe.
    - Always → IDLE.
- Simultaneous sclk rise and ncs rise in the same clk cycle: the shift is applied first, then COMMIT evaluates the updated count.
- Latency: let T0 be the first clk edge that samples raw ncs high. The register updates and wr_strobe asserts on edge T0+SYNC_STAGES+1.
- Reset released while ncs is low: FSM stays in IDLE until ncs is seen high, then falls. A partial frame is never accepted.
- Reset mid-frame: frame lost; registers return to 0.
- Registers hold their value indefinitely between writes. Only the 8 data bits are stored.

Optional Feature:
- Macro SPI_READBACK_EN.
- Defined:
  - A frame with R/W==0 is a read.
  - After bit 8 (address complete), cipo presents reg[addr] MSB first, bit 7 first.
  - Each following bit is updated on each synchronised sclk falling edge for bits 8..15.
  - Invalid addresses read 0x00. Reads never modify registers or pulse wr_strobe.
  - cipo returns to 0 in IDLE.
- Undefined: cipo tied to 0; R/W==0 frames are discarded in COMMIT.

Decomposition:
- Package spi_reg_pkg holds:
  - TXN_BITS=16.
  - Address constants ADDR_EN_OUT_7_0=7'h00, ADDR_EN_OUT_15_8=7'h01, ADDR_EN_PWM_7_0=7'h02, ADDR_EN_PWM_15_8=7'h03, ADDR_PWM_DUTY=7'h04.
  - FSM state enum.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs.
  - Instantiated for ncs and sclk; copi uses its sync output only.

Test Plan:
- Write frame 0x80F0, then 0x84_80 → en_reg_out_7_0=0xF0 and pwm_duty_cycle=0x80; wr_strobe pulses twice with wr_addr 0x00 then 0x04; other registers stay 0.
- Frame 0x8555 (addr 0x05 ≥ NUM_REGS), then 0x0312 (read to addr 3) → no register change, no wr_strobe.
- 15-bit frame and 17-bit frame each carrying a write of 0xAA to addr 2 → both discarded; en_reg_pwm_7_0 stays 0x00.
- Assert rst after 9 bits of frame 0x81FF with ncs held low, release it, finish the frame → nothing written; the next full frame 0x81FF → en_reg_out_15_8=0xFF.
- Final sclk rise coincident with ncs rise (same clk cycle), frame 0x8233 → en_reg_pwm_7_0=0x33 exactly SYNC_STAGES+1 cycles after T0.
- SPI_READBACK_EN: write 0x835A, then read 0x0300 → cipo bits 8..15 are 0x5A MSB first; read 0x0700 → 0x00.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants and types for the SPI register peripheral.
//   TXN_BITS    - length of a well-formed SPI frame (R/W + 7-bit addr + 8-bit data)
//   ADDR_*      - register map consumed by pwm_peripheral
//   state_t     - frame FSM states
package spi_reg_pkg;

  localparam int TXN_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_reg_peripheral_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous input, with
// single-cycle rise/fall pulses derived from the synchronised value and a
// one-cycle-delayed copy of it.
//   clk, rst - system clock, asynchronous active-high reset
//   din      - asynchronous input
//   sync     - synchronised level
//   rise     - one-cycle pulse on a synchronised 0->1 transition
//   fall     - one-cycle pulse on a synchronised 1->0 transition
// Edge pulses are held off until the chain and its delayed copy contain only
// real samples; otherwise the reset idle value could fake an edge (e.g. ncs
// held low across reset would look like a falling edge right after release).
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic [SYNC_STAGES:0]   fill;
  logic                   primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{IDLE_VAL}};
      prev  <= IDLE_VAL;
      fill  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync   = chain[SYNC_STAGES-1];
  assign primed = fill[SYNC_STAGES];
  assign rise   = primed &  sync & ~prev;
  assign fall   = primed & ~sync &  prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: SPI mode-0 target holding the five 8-bit control
// registers of pwm_peripheral. Frames are 16 bits, MSB first:
// bit15 R/W (1 = write), bits14:8 address, bits7:0 data.
//   clk, rst          - system clock, asynchronous active-high reset
//   ncs, sclk, copi   - asynchronous SPI inputs (synchronised internally)
//   cipo              - SPI data out (register readback when SPI_READBACK_EN
//                       is defined, otherwise constant 0)
//   en_reg_out_7_0 .. pwm_duty_cycle - registers 0x00..0x04
//   wr_strobe         - one-cycle pulse when a register is written
//   wr_addr           - address of the last accepted write
// Optional build macro: SPI_READBACK_EN (R/W==0 frames return reg[addr]).
import spi_reg_pkg::*;

module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic [6:0] wr_addr
);

  localparam logic [4:0] CNT_FULL   = 5'(TXN_BITS);
  localparam logic [4:0] CNT_SAT    = 5'(TXN_BITS + 1);
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic ncs_s, ncs_rise, ncs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] copi_chain;
  logic copi_s;

  state_t state, state_next;
  logic [TXN_BITS-1:0] shift_q;
  logic [4:0]          count_q;
  logic [6:0]          frame_addr;
  logic [7:0]          frame_data;
  logic                frame_ok;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ncs_sync (
    .clk(clk), .rst(rst), .din(ncs), .sync(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  // copi only needs to be stable when sampled on an sclk rise, so a level
  // synchroniser is enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) copi_chain <= '0;
    else     copi_chain <= {copi_chain[SYNC_STAGES-2:0], copi};
  end
  assign copi_s = copi_chain[SYNC_STAGES-1];

  // Levels are consumed through their edge pulses only.
  logic unused_levels;
  assign unused_levels = &{1'b0, ncs_s, sclk_s, sclk_fall};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (ncs_fall) state_next = ST_SHIFT;
      ST_SHIFT:  if (ncs_rise) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign frame_ok   = (count_q == CNT_FULL) && shift_q[15] &&
                      ({1'b0, frame_addr} < NUM_REGS_W);

  // A final sclk rise landing in the same cycle as the ncs rise is still
  // shifted here, so COMMIT sees the completed count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q         <= '0;
      count_q         <= '0;
      wr_strobe       <= 1'b0;
      wr_addr         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (state == ST_IDLE && ncs_fall) begin
        shift_q <= '0;
        count_q <= '0;
      end else if (state == ST_SHIFT && sclk_rise) begin
        shift_q <= {shift_q[TXN_BITS-2:0], copi_s};
        if (count_q != CNT_SAT) count_q <= count_q + 5'd1;
      end
      if (state == ST_COMMIT && frame_ok) begin
        wr_strobe <= 1'b1;
        wr_addr   <= frame_addr;
        case (frame_addr)
          ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= frame_data;
          ADDR_EN_OUT_15_8: en_reg_out_15_8 <= frame_data;
          ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= frame_data;
          ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= frame_data;
          ADDR_PWM_DUTY:    pwm_duty_cycle  <= frame_data;
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [7:0] rd_sel;
  logic [7:0] tx_q;
  logic       cipo_q;

  // After 8 bits the low byte of shift_q holds {R/W, addr}.
  always_comb begin
    rd_sel = '0;
    if ({1'b0, shift_q[6:0]} < NUM_REGS_W) begin
      case (shift_q[6:0])
        ADDR_EN_OUT_7_0:  rd_sel = en_reg_out_7_0;
        ADDR_EN_OUT_15_8: rd_sel = en_reg_out_15_8;
        ADDR_EN_PWM_7_0:  rd_sel = en_reg_pwm_7_0;
        ADDR_EN_PWM_15_8: rd_sel = en_reg_pwm_15_8;
        ADDR_PWM_DUTY:    rd_sel = pwm_duty_cycle;
        default:          rd_sel = '0;
      endcase
    end
  end

  // Data bit 7 is presented on the sclk fall after the 8th rise so the
  // controller samples it on the 9th rise; later falls shift the rest out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else if (state != ST_SHIFT) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else if (sclk_fall) begin
      if (count_q == 5'd8 && !shift_q[7]) begin
        cipo_q <= rd_sel[7];
        tx_q   <= {rd_sel[6:0], 1'b0};
      end else if (count_q > 5'd8 && count_q < CNT_FULL) begin
        cipo_q <= tx_q[7];
        tx_q   <= {tx_q[6:0], 1'b0};
      end
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: directed bench for spi_reg_peripheral.
// Define SPI_READBACK_EN for both DUT and bench to exercise readback.
module tb_spi_reg_peripheral;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ncs = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;
  logic [6:0] wr_addr;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  logic [6:0] addr_q[$];

  spi_reg_peripheral #(.SYNC_STAGES(SYNC), .NUM_REGS(5)) dut (
    .clk(clk), .rst(rst), .ncs(ncs), .sclk(sclk), .copi(copi), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  // strobe monitor: wr_strobe is one cycle wide, so each negedge hit is one write
  always @(negedge clk) begin
    if (!rst && wr_strobe === 1'b1) begin
      strobe_cnt++;
      addr_q.push_back(wr_addr);
    end
  end

  // driver tasks (sclk = clk/8)
  task automatic spi_bit(input logic b);
    @(negedge clk) copi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] v, input int n);
    @(negedge clk) ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'h0) begin
      bad++; $display("FAIL reset_regs got=%h want=0", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
    end
    total++;
    if ({wr_strobe, wr_addr, cipo} !== 9'h0) begin
      bad++; $display("FAIL reset_ctrl got=%h want=0", {wr_strobe, wr_addr, cipo});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if ({en_reg_out_7_0, pwm_duty_cycle, wr_strobe} !== 17'h0) begin
      bad++; $display("FAIL post_reset got=%h want=0", {en_reg_out_7_0, pwm_duty_cycle, wr_strobe});
    end
  endtask

  task automatic test_basic_write;
    int base;
    base = strobe_cnt;
    addr_q.delete();
    spi_frame(32'h80F0, 16);
    spi_frame(32'h8480, 16);
    total++;
    if (en_reg_out_7_0 !== 8'hF0) begin bad++; $display("FAIL wr_reg0 got=%h want=f0", en_reg_out_7_0); end
    total++;
    if (pwm_duty_cycle !== 8'h80) begin bad++; $display("FAIL wr_reg4 got=%h want=80", pwm_duty_cycle); end
    total++;
    if ({en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8} !== 24'h0) begin
      bad++; $display("FAIL wr_others got=%h want=0", {en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8});
    end
    total++;
    if (strobe_cnt - base !== 2) begin bad++; $display("FAIL wr_strobe_cnt got=%0d want=2", strobe_cnt - base); end
    total++;
    if (addr_q.size() != 2 || addr_q[0] !== 7'h00 || addr_q[1] !== 7'h04) begin
      bad++; $display("FAIL wr_addr_seq got_n=%0d want 00,04", addr_q.size());
    end
    total++;
    if (wr_addr !== 7'h04) begin bad++; $display("FAIL wr_addr_hold got=%h want=04", wr_addr); end
  endtask

  task automatic test_discard;
    int base;
    base = strobe_cnt;
    spi_frame(32'h8555, 16);
    spi_frame(32'h0312, 16);
    total++;
    if (strobe_cnt !== base) begin bad++; $display("FAIL discard_strobe got=%0d want=%0d", strobe_cnt, base); end
    total++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'hF0_00_00_00_80) begin
      bad++; $display("FAIL discard_regs got=%h want=f000000080", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
    end
    total++;
    if (cipo !== 1'b0) begin bad++; $display("FAIL idle_cipo got=%b want=0", cipo); end
  endtask

  task automatic test_bad_length;
    int base;
    base = strobe_cnt;
    spi_frame(32'h4155, 15);    // top 15 bits of 0x82AA
    total++;
    if (en_reg_pwm_7_0 !== 8'h00) begin bad++; $display("FAIL len15 got=%h want=00", en_reg_pwm_7_0); end
    spi_frame(32'h10554, 17);   // 0x82AA plus one extra bit
    total++;
    if (en_reg_pwm_7_0 !== 8'h00) begin bad++; $display("FAIL len17 got=%h want=00", en_reg_pwm_7_0); end
    total++;
    if (strobe_cnt !== base) begin bad++; $display("FAIL len_strobe got=%0d want=%0d", strobe_cnt, base); end
  endtask

  task automatic test_midframe_reset;
    int base;
    logic [15:0] v;
    v = 16'h81FF;
    @(negedge clk) ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 15; i >= 7; i--) spi_bit(v[i]);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({en_reg_out_7_0, pwm_duty_cycle} !== 16'h0) begin
      bad++; $display("FAIL midrst_clear got=%h want=0", {en_reg_out_7_0, pwm_duty_cycle});
    end
    rst = 1'b0;
    base = strobe_cnt;
    for (int i = 6; i >= 0; i--) spi_bit(v[i]);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (en_reg_out_15_8 !== 8'h00 || strobe_cnt !== base) begin
      bad++; $display("FAIL midrst_partial got=%h/%0d want=00/%0d", en_reg_out_15_8, strobe_cnt, base);
    end
    spi_frame(32'h81FF, 16);
    total++;
    if (en_reg_out_15_8 !== 8'hFF) begin bad++; $display("FAIL midrst_next got=%h want=ff", en_reg_out_15_8); end
  endtask

  task automatic test_coincident_end;
    logic [15:0] v;
    v = 16'h8233;
    @(negedge clk) ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 15; i >= 1; i--) spi_bit(v[i]);
    @(negedge clk) copi = v[0];
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    ncs = 1'b1;
    @(posedge clk);                 // T0
    repeat (SYNC) @(posedge clk);
    #1;
    total++;
    if (en_reg_pwm_7_0 !== 8'h00 || wr_strobe !== 1'b0) begin
      bad++; $display("FAIL lat_early got=%h/%b want=00/0", en_reg_pwm_7_0, wr_strobe);
    end
    @(posedge clk);                 // T0+SYNC+1
    #1;
    total++;
    if (en_reg_pwm_7_0 !== 8'h33 || wr_strobe !== 1'b1 || wr_addr !== 7'h02) begin
      bad++; $display("FAIL lat_hit got=%h/%b/%h want=33/1/02", en_reg_pwm_7_0, wr_strobe, wr_addr);
    end
    @(posedge clk);
    #1;
    total++;
    if (wr_strobe !== 1'b0) begin bad++; $display("FAIL lat_pulse got=%b want=0", wr_strobe); end
    @(negedge clk) sclk = 1'b0;
    repeat (12) @(negedge clk);
  endtask

`ifdef SPI_READBACK_EN
  task automatic spi_read(input logic [15:0] v, output logic [7:0] rd);
    rd = '0;
    @(negedge clk) ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk) copi = v[i];
      repeat (4) @(negedge clk);
      if (i <= 7) rd[i] = cipo;     // what the controller samples on this rise
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_readback;
    logic [7:0] rd;
    int base;
    spi_frame(32'h835A, 16);
    base = strobe_cnt;
    spi_read(16'h0300, rd);
    total++;
    if (rd !== 8'h5A) begin bad++; $display("FAIL rb_reg3 got=%h want=5a", rd); end
    spi_read(16'h0700, rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL rb_invalid got=%h want=00", rd); end
    total++;
    if (strobe_cnt !== base || en_reg_pwm_15_8 !== 8'h5A || cipo !== 1'b0) begin
      bad++; $display("FAIL rb_side got=%0d/%h/%b want=%0d/5a/0", strobe_cnt, en_reg_pwm_15_8, cipo, base);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic_write;
    test_discard;
    test_bad_length;
    test_midframe_reset;
    test_coincident_end;
`ifdef SPI_READBACK_EN
    test_readback;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
